uart_result_tx: RTL

Transmit side of the UART ALU link: accepts a DATA_BYTES-wide result word over a valid/ready handshake and serializes it onto the TX pin as back-to-back 8N1 UART frames, least-significant byte first. Sits between the ALU datapath and the board `TX` pin, clocked from the 32.256 MHz PLL domain. 32.256 MHz / 115200 baud gives an exact 280-cycle bit period.

---
 rtl/uart_alu_pkg.sv | 20 ++
 rtl/uart_tx_byte.sv | 104 ++++++++++
 rtl/uart_result_tx.sv | 83 ++++++++
 3 files changed

// File: rtl/uart_alu_pkg.sv
// Shared constants, baud arithmetic and FSM state type for the UART ALU link.
package uart_alu_pkg;

    localparam int CLK_HZ_DEFAULT = 32_256_000;
    localparam int BAUD_DEFAULT   = 115_200;
    localparam int BYTE_W         = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_e;

    // Integer clock cycles per bit; any remainder is dropped.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 framer. A byte offered at the last cycle of a stop bit is
// chained straight into the next start bit, so multi-byte words have no gap.
//
// state | meaning
// IDLE  | line high, waiting for a byte
// START | start bit (low) for one bit period
// DATA  | 8 data bits, LSB first
// STOP  | stop bit (high); may chain directly into the next START
module uart_tx_byte
    import uart_alu_pkg::*;
#(
    parameter int CLKS_PER_BIT = 280
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              done_o,
    output logic              tx_o
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    uart_tx_state_e    state_q;
    logic [BAUD_W-1:0] baud_q;
    logic [2:0]        bit_q;
    logic [BYTE_W-1:0] shift_q;
    logic              tx_q;
    logic              bit_end;

    assign bit_end = (baud_q == BAUD_LAST);
    assign done_o  = (state_q == STOP) && bit_end;
    assign ready_o = (state_q == IDLE) || done_o;
    assign tx_o    = tx_q;

    // Framing FSM: baud counter restarts at every bit boundary so bit periods stay exact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    baud_q <= '0;
                    if (valid_i) begin
                        state_q <= START;
                        shift_q <= data_i;
                        tx_q    <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_q  <= '0;
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                        shift_q <= {1'b0, shift_q[BYTE_W-1:1]};
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                            bit_q   <= '0;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            tx_q    <= shift_q[0];
                            shift_q <= {1'b0, shift_q[BYTE_W-1:1]};
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        if (valid_i) begin
                            state_q <= START;
                            shift_q <= data_i;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_result_tx.sv
// Word-level UART transmitter: accepts a DATA_BYTES result word and sends it
// LSB byte first as back-to-back 8N1 frames through uart_tx_byte.
module uart_result_tx
    import uart_alu_pkg::*;
#(
    parameter int CLK_HZ     = CLK_HZ_DEFAULT,
    parameter int BAUD       = BAUD_DEFAULT,
    parameter int DATA_BYTES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [BYTE_W*DATA_BYTES-1:0] data_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    output logic                         tx_o,
    output logic                         busy_o
);

    localparam int               CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int               WORD_W       = BYTE_W * DATA_BYTES;
    localparam int               IDX_W        = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(DATA_BYTES - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_result_tx: CLK_HZ/BAUD must be at least 2");
    end
    if (DATA_BYTES < 1) begin : g_bad_bytes
        $error("uart_result_tx: DATA_BYTES must be at least 1");
    end

    logic              busy_q;
    logic [IDX_W-1:0]  idx_q;
    logic [WORD_W-1:0] word_q;
    logic              accept;
    logic              advance;
    logic              byte_valid;
    logic [BYTE_W-1:0] byte_data;
    logic              byte_ready;
    logic              byte_done;

    // Byte 0 goes straight from data_i so the start bit begins on the accept edge;
    // word_q holds the remaining bytes, next one always in the low lane.
    assign ready_o    = !busy_q && byte_ready;
    assign accept     = valid_i && ready_o;
    assign advance    = byte_done && (idx_q != LAST_IDX);
    assign byte_valid = accept || advance;
    assign byte_data  = accept ? data_i[BYTE_W-1:0] : word_q[BYTE_W-1:0];
    assign busy_o     = busy_q;

    // Word sequencing: capture on accept, shift one byte per completed frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            idx_q  <= '0;
            word_q <= '0;
        end else if (accept) begin
            busy_q <= 1'b1;
            idx_q  <= '0;
            word_q <= data_i >> BYTE_W;
        end else if (byte_done) begin
            if (idx_q == LAST_IDX) begin
                busy_q <= 1'b0;
                idx_q  <= '0;
            end else begin
                idx_q  <= idx_q + IDX_W'(1);
                word_q <= word_q >> BYTE_W;
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .clk    (clk),
        .rst_n  (rst_n),
        .data_i (byte_data),
        .valid_i(byte_valid),
        .ready_o(byte_ready),
        .done_o (byte_done),
        .tx_o   (tx_o)
    );

endmodule
